// File: rtl/minisys_mem_pkg.sv
// minisys_mem_pkg: shared width encodings, FSM states and alignment helper for the memory/IO access unit
package minisys_mem_pkg;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b11;
  localparam int IO_ADDR_W = 10;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MEM, S_IO, S_DONE} state_t;
  function automatic logic misaligned(input logic [1:0] w, input logic [1:0] a);
    return (w == 2'b10) || (w == W_HALF && a[0]) || (w == W_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable generation, store replication and load lane extraction/extension
module mem_lane_align
  import minisys_mem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] load
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  assign shifted = rword >> {lane, 3'b000};
  assign b = shifted[7:0];
  assign h = lane[1] ? rword[31:16] : rword[15:0];
  always_comb begin
    be   = width == W_BYTE ? 4'b0001 << lane : width == W_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = width == W_BYTE ? {4{wdata[7:0]}} : width == W_HALF ? {2{wdata[15:0]}} : wdata;
    load = width == W_BYTE ? {{24{sign_ext & b[7]}}, b} :
           width == W_HALF ? {{16{sign_ext & h[15]}}, h} : rword;
  end
endmodule

// File: rtl/mem_io_access.sv
// mem_io_access: multicycle RAM/IO load-store unit with alignment check, req/ack handshake and IO timeout
module mem_io_access
  import minisys_mem_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int IO_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [1:0]           data_width,
  input  logic                 sign_ext,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          rdata,
  output logic                 addr_err,
  output logic                 bus_err,
  output logic [31:0]          bad_vaddr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [3:0]           mem_be,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic                 io_rd,
  output logic                 io_wr,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [31:0]          io_wdata,
  input  logic [31:0]          io_rdata,
  input  logic                 io_ready
);
  state_t state, state_n;
  logic [3:0]  cmd;
  logic [31:0] a_q, d_q;
  logic [1:0]  w_q;
  logic        s_q;
  logic [7:0]  cnt;
  logic        aerr_q, berr_q;
  logic [3:0]  be;
  logic [31:0] wrep, load;
  logic        conflict, none, misal, timeout, a_fault;
  assign conflict = $countones(cmd) > 1;
  assign none     = cmd == 4'b0000;
  assign misal    = misaligned(w_q, a_q[1:0]);
  assign a_fault  = !conflict && !none && misal;
  assign timeout  = cnt == 8'(IO_TIMEOUT - 1);
  mem_lane_align u_align (
    .width    (w_q),
    .lane     (a_q[1:0]),
    .sign_ext (s_q),
    .wdata    (d_q),
    .rword    (state == S_IO ? io_rdata : mem_rdata),
    .be       (be),
    .wrep     (wrep),
    .load     (load)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_CHECK : S_IDLE;
      S_CHECK: state_n = (conflict || none || misal) ? S_DONE : (|cmd[3:2]) ? S_MEM : S_IO;
      S_MEM:   state_n = mem_ack ? S_DONE : S_MEM;
      S_IO:    state_n = (io_ready || timeout) ? S_DONE : S_IO;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  // cmd bits: {mem_read, mem_write, io_read, io_write}
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd       <= '0;
      a_q       <= '0;
      d_q       <= '0;
      w_q       <= '0;
      s_q       <= 1'b0;
      cnt       <= '0;
      aerr_q    <= 1'b0;
      berr_q    <= 1'b0;
      rdata     <= '0;
      bad_vaddr <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cmd <= {mem_read, mem_write, io_read, io_write};
        a_q <= addr;
        d_q <= wdata;
        w_q <= data_width;
        s_q <= sign_ext;
      end
      if (state == S_CHECK) begin
        berr_q <= conflict;
        aerr_q <= a_fault;
        if (a_fault) bad_vaddr <= a_q;
      end
      if (state == S_MEM && mem_ack && cmd[3]) rdata <= load;
      cnt <= state == S_IO ? cnt + 8'd1 : 8'd0;
      if (state == S_IO && io_ready && cmd[1]) rdata <= load;
      if (state == S_IO && !io_ready && timeout) begin
        berr_q <= 1'b1;
        rdata  <= '0;
      end
    end
  end
  always_comb begin
    busy      = state == S_CHECK || state == S_MEM || state == S_IO;
    done      = state == S_DONE;
    addr_err  = done && aerr_q;
    bus_err   = done && berr_q;
    mem_req   = state == S_MEM;
    mem_we    = mem_req && cmd[2];
    mem_addr  = mem_req ? a_q[ADDR_W+1:2] : '0;
    mem_be    = mem_req ? be : 4'b0000;
    mem_wdata = mem_req ? wrep : '0;
    io_rd     = state == S_IO && cmd[1];
    io_wr     = state == S_IO && cmd[0];
    io_addr   = state == S_IO ? a_q[IO_ADDR_W-1:0] : '0;
    io_wdata  = state == S_IO ? wrep : '0;
  end
endmodule
